red_pitaya_sys_arb: RTL and testbench
=====================================

// Module: red_pitaya_sys_arb
// PURPOSE
//  Two-master arbiter in front of one system-bus slave (e.g. housekeeping regs).
//  Latches single-cycle wen/ren pulses from each master and forwards one transaction
//  at a time; round-robin or fixed priority. Returns ack/err/rdata to the owner.
//  Times out unresponsive slaves with an error.
// PARAMETERS
//  FIXED_PRIO  0    0: round-robin; 1: master 0 always wins a tie
//  TMO         255  max cycles in WAIT before forced error completion (1..65535)
// PORTS
//  clk_i       in   1   clock
//  rst_i       in   1   asynchronous reset, active high
//  m0_addr_i   in   32  master 0 address (m1_* identical for master 1)
//  m0_wdata_i  in   32  master 0 write data
//  m0_sel_i    in   4   master 0 byte select
//  m0_wen_i    in   1   master 0 write pulse
//  m0_ren_i    in   1   master 0 read pulse
//  m0_rdata_o  out  32  read data to master 0, valid while m0_ack_o
//  m0_err_o    out  1   error pulse to master 0
//  m0_ack_o    out  1   acknowledge pulse to master 0
//  sys_addr_o  out  32  slave address
//  sys_wdata_o out  32  slave write data
//  sys_sel_o   out  4   slave byte select
//  sys_wen_o   out  1   slave write pulse
//  sys_ren_o   out  1   slave read pulse
//  sys_rdata_i in   32  slave read data
//  sys_err_i   in   1   slave error
//  sys_ack_i   in   1   slave acknowledge
// BEHAVIOUR
//  Reset: all outputs 0; pending[1:0]=0; state=IDLE; last=1 (master 0 wins first).
//  Capture: wen|ren at cycle n with pending[i]=0 latches addr/wdata/sel/wen/ren,
//   sets pending[i] at n+1. wen&ren together = read+write forwarded as given.
//  Overrun: pulse while pending[i]=1 -> not forwarded; mi_ack_o=mi_err_o=1,
//   rdata=0 at n+1; the pending transaction is unaffected.
//  FSM IDLE: any pending -> pick grant (both: FIXED_PRIO?0 : ~last), -> ISSUE.
//  ISSUE (1 cycle): sys_addr/wdata/sel from grant latch; sys_wen_o/sys_ren_o = latched
//   wen/ren for this cycle only; timer cleared; -> WAIT.
//  WAIT: sys_ack_i|sys_err_i -> next cycle mi_ack_o=1, mi_err_o=sys_err_i,
//   mi_rdata_o=sys_rdata_i (registered), pending[grant]=0, last=grant, -> IDLE.
//   timer==TMO-1 with no ack -> next cycle mi_ack_o=1, mi_err_o=1, rdata=0; -> IDLE.
//  sys_addr/wdata/sel hold last issued values outside ISSUE; wen/ren are 0.
//  sys_ack_i/sys_err_i outside WAIT ignored. Timer saturates; 16-bit.
//  Latency (1-cycle slave): req n, pending n+1, ISSUE n+2, slave ack n+3, mi_ack n+4.
//  Other master's capture during a busy transaction proceeds; served on next IDLE
//   (one idle cycle between back-to-back transactions).
//  Ack pulses: exactly one cycle; mi_rdata_o returns to 0 when mi_ack_o=0.
//  Reset mid-transaction: transaction abandoned, no ack emitted, all state cleared.
// TESTING
//  m0 read 0x00 vs 1-cycle slave returning 0x1 -> sys_ren_o at n+2, m0_ack_o, rdata=0x1 at n+4.
//  m0 write & m1 read same cycle, FIXED_PRIO=0 -> m0 served first, m1 ISSUE 3 cycles later;
//   repeat -> m1 first on second tie? no: last=m1 so m0 first again; alternation verified.
//  FIXED_PRIO=1, m1 pending, m0 re-requests every completion -> m0 wins all ties, m1 waits.
//  Slave never acks, TMO=8 -> m0_ack_o=1,m0_err_o=1,rdata=0 exactly 8 cycles after ISSUE.
//  m1 second pulse while pending -> immediate m1 err pulse, single sys_ren_o only.
//  rst_i asserted during WAIT -> all outputs 0 same cycle; no ack after release.

Source files
------------

// File: rtl/red_pitaya_sys_arb.sv
// Two-master arbiter in front of a single system-bus slave: captures request pulses,
// forwards one transaction at a time and routes ack/err/rdata back to the owner.
module red_pitaya_sys_arb #(
    parameter int FIXED_PRIO = 0,
    parameter int TMO        = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_wen_i,
    input  logic        m0_ren_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    output logic        m0_ack_o,

    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_wen_i,
    input  logic        m1_ren_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        m1_ack_o,

    output logic [31:0] sys_addr_o,
    output logic [31:0] sys_wdata_o,
    output logic [3:0]  sys_sel_o,
    output logic        sys_wen_o,
    output logic        sys_ren_o,
    input  logic [31:0] sys_rdata_i,
    input  logic        sys_err_i,
    input  logic        sys_ack_i
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_ISSUE  = 2'd1;
    localparam logic [1:0]  S_WAIT   = 2'd2;
    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    logic [1:0]  r_state;
    logic [1:0]  r_pend;
    logic        r_last;
    logic        r_grant;
    logic [15:0] r_timer;

    logic [31:0] r_addr  [2];
    logic [31:0] r_wdata [2];
    logic [3:0]  r_sel   [2];
    logic [1:0]  r_wen;
    logic [1:0]  r_ren;

    logic [31:0] r_sysAddr;
    logic [31:0] r_sysWdata;
    logic [3:0]  r_sysSel;
    logic        r_sysWen;
    logic        r_sysRen;

    logic [1:0]  r_ack;
    logic [1:0]  r_err;
    logic [31:0] r_rdata [2];

    logic [31:0] w_addrIn  [2];
    logic [31:0] w_wdataIn [2];
    logic [3:0]  w_selIn   [2];
    logic [1:0]  w_wenIn;
    logic [1:0]  w_renIn;
    logic [1:0]  w_req;
    logic [1:0]  w_capture;
    logic [1:0]  w_overrun;
    logic [1:0]  w_own;
    logic        w_slaveResp;
    logic        w_done;
    logic        w_timeout;
    logic        w_finish;
    logic        w_pick;

    assign w_addrIn[0]  = m0_addr_i;
    assign w_addrIn[1]  = m1_addr_i;
    assign w_wdataIn[0] = m0_wdata_i;
    assign w_wdataIn[1] = m1_wdata_i;
    assign w_selIn[0]   = m0_sel_i;
    assign w_selIn[1]   = m1_sel_i;
    assign w_wenIn      = {m1_wen_i, m0_wen_i};
    assign w_renIn      = {m1_ren_i, m0_ren_i};

    assign w_req       = w_wenIn | w_renIn;
    assign w_capture   = w_req & ~r_pend;
    assign w_overrun   = w_req & r_pend;
    assign w_own       = {r_grant, ~r_grant};
    assign w_slaveResp = sys_ack_i | sys_err_i;
    assign w_done      = (r_state == S_WAIT) && w_slaveResp;
    assign w_timeout   = (r_state == S_WAIT) && !w_slaveResp && (r_timer >= TMO_LAST);
    assign w_finish    = w_done | w_timeout;

    // On a tie, round-robin favours whoever was not served last; otherwise master 0.
    assign w_pick = (&r_pend) ? ((FIXED_PRIO != 0) ? 1'b0 : ~r_last) : r_pend[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend <= '0;
            r_wen  <= '0;
            r_ren  <= '0;
            for (int i = 0; i < 2; i++) begin
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
                r_sel[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_capture[i]) begin
                    r_addr[i]  <= w_addrIn[i];
                    r_wdata[i] <= w_wdataIn[i];
                    r_sel[i]   <= w_selIn[i];
                    r_wen[i]   <= w_wenIn[i];
                    r_ren[i]   <= w_renIn[i];
                end
                r_pend[i] <= w_capture[i] | (r_pend[i] & ~(w_finish & w_own[i]));
            end
        end
    end

    // Overrun pulses are answered immediately with an error and never reach the slave.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack <= '0;
            r_err <= '0;
            for (int i = 0; i < 2; i++) begin
                r_rdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_ack[i]   <= w_overrun[i] | (w_finish & w_own[i]);
                r_err[i]   <= w_overrun[i] | (w_finish & w_own[i] & (w_timeout | sys_err_i));
                r_rdata[i] <= (w_done && w_own[i]) ? sys_rdata_i : '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_grant    <= 1'b0;
            r_timer    <= '0;
            r_sysAddr  <= '0;
            r_sysWdata <= '0;
            r_sysSel   <= '0;
            r_sysWen   <= 1'b0;
            r_sysRen   <= 1'b0;
        end else begin
            r_sysWen <= 1'b0;
            r_sysRen <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|r_pend) begin
                        r_grant    <= w_pick;
                        r_sysAddr  <= r_addr[w_pick];
                        r_sysWdata <= r_wdata[w_pick];
                        r_sysSel   <= r_sel[w_pick];
                        r_sysWen   <= r_wen[w_pick];
                        r_sysRen   <= r_ren[w_pick];
                        r_timer    <= '0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= r_timer + 16'd1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_timer != 16'hFFFF) begin
                        r_timer <= r_timer + 16'd1;
                    end
                    if (w_finish) begin
                        r_last  <= r_grant;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sys_addr_o  = r_sysAddr;
    assign sys_wdata_o = r_sysWdata;
    assign sys_sel_o   = r_sysSel;
    assign sys_wen_o   = r_sysWen;
    assign sys_ren_o   = r_sysRen;

    assign m0_ack_o   = r_ack[0];
    assign m0_err_o   = r_err[0];
    assign m0_rdata_o = r_rdata[0];
    assign m1_ack_o   = r_ack[1];
    assign m1_err_o   = r_err[1];
    assign m1_rdata_o = r_rdata[1];

endmodule

// File: tb/tb_red_pitaya_sys_arb.sv
// Directed bench: a round-robin and a fixed-priority arbiter share the same master
// stimulus, each with its own 1-cycle slave model.
module tb_red_pitaya_sys_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] m0Addr = '0, m0Wdata = '0, m1Addr = '0, m1Wdata = '0;
    logic [3:0]  m0Sel = 4'hF, m1Sel = 4'h5;
    logic        m0Wen = 1'b0, m0Ren = 1'b0, m1Wen = 1'b0, m1Ren = 1'b0;
    logic        slaveEn = 1'b1;

    logic [31:0] d0M0Rdata, d0M1Rdata, d0SysAddr, d0SysWdata, s0Rdata;
    logic        d0M0Err, d0M0Ack, d0M1Err, d0M1Ack, d0SysWen, d0SysRen, s0Err, s0Ack;
    logic [3:0]  d0SysSel;
    logic [31:0] d1M0Rdata, d1M1Rdata, d1SysAddr, d1SysWdata, s1Rdata;
    logic        d1M0Err, d1M0Ack, d1M1Err, d1M1Ack, d1SysWen, d1SysRen, s1Err, s1Ack;
    logic [3:0]  d1SysSel;

    int errors = 0;
    int checks = 0;
    int ren0Count = 0;
    int ack0Count = 0;
    int base;

    always #5 clk = ~clk;

    red_pitaya_sys_arb #(.FIXED_PRIO(0), .TMO(8)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .m0_addr_i(m0Addr), .m0_wdata_i(m0Wdata), .m0_sel_i(m0Sel),
        .m0_wen_i(m0Wen), .m0_ren_i(m0Ren),
        .m0_rdata_o(d0M0Rdata), .m0_err_o(d0M0Err), .m0_ack_o(d0M0Ack),
        .m1_addr_i(m1Addr), .m1_wdata_i(m1Wdata), .m1_sel_i(m1Sel),
        .m1_wen_i(m1Wen), .m1_ren_i(m1Ren),
        .m1_rdata_o(d0M1Rdata), .m1_err_o(d0M1Err), .m1_ack_o(d0M1Ack),
        .sys_addr_o(d0SysAddr), .sys_wdata_o(d0SysWdata), .sys_sel_o(d0SysSel),
        .sys_wen_o(d0SysWen), .sys_ren_o(d0SysRen),
        .sys_rdata_i(s0Rdata), .sys_err_i(s0Err), .sys_ack_i(s0Ack)
    );

    red_pitaya_sys_arb #(.FIXED_PRIO(1), .TMO(8)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .m0_addr_i(m0Addr), .m0_wdata_i(m0Wdata), .m0_sel_i(m0Sel),
        .m0_wen_i(m0Wen), .m0_ren_i(m0Ren),
        .m0_rdata_o(d1M0Rdata), .m0_err_o(d1M0Err), .m0_ack_o(d1M0Ack),
        .m1_addr_i(m1Addr), .m1_wdata_i(m1Wdata), .m1_sel_i(m1Sel),
        .m1_wen_i(m1Wen), .m1_ren_i(m1Ren),
        .m1_rdata_o(d1M1Rdata), .m1_err_o(d1M1Err), .m1_ack_o(d1M1Ack),
        .sys_addr_o(d1SysAddr), .sys_wdata_o(d1SysWdata), .sys_sel_o(d1SysSel),
        .sys_wen_o(d1SysWen), .sys_ren_o(d1SysRen),
        .sys_rdata_i(s1Rdata), .sys_err_i(s1Err), .sys_ack_i(s1Ack)
    );

    // Slave models answer one cycle after a request; address 0xBAD0 answers with an error.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s0Ack <= 1'b0; s0Err <= 1'b0; s0Rdata <= '0;
            s1Ack <= 1'b0; s1Err <= 1'b0; s1Rdata <= '0;
        end else begin
            s0Ack   <= slaveEn && (d0SysWen || d0SysRen) && (d0SysAddr != 32'hBAD0);
            s0Err   <= slaveEn && (d0SysWen || d0SysRen) && (d0SysAddr == 32'hBAD0);
            s0Rdata <= (slaveEn && d0SysRen) ? d0SysAddr + 32'd1 : 32'd0;
            s1Ack   <= slaveEn && (d1SysWen || d1SysRen) && (d1SysAddr != 32'hBAD0);
            s1Err   <= slaveEn && (d1SysWen || d1SysRen) && (d1SysAddr == 32'hBAD0);
            s1Rdata <= (slaveEn && d1SysRen) ? d1SysAddr + 32'd1 : 32'd0;
        end
    end

    always @(posedge clk) begin
        if (d0SysRen) ren0Count <= ren0Count + 1;
        if (d0M0Ack)  ack0Count <= ack0Count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Drives one-cycle request pulses in the current cycle and returns in the next one.
    task automatic applyStimulus(input logic w0, input logic r0, input logic w1, input logic r1,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] wd0);
        m0Wen = w0; m0Ren = r0; m1Wen = w1; m1Ren = r1;
        m0Addr = a0; m1Addr = a1; m0Wdata = wd0;
        tick();
        m0Wen = 1'b0; m0Ren = 1'b0; m1Wen = 1'b0; m1Ren = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        $display("[TB] start");
        ticks(2);
        sample();
        checkOutput("rst sys_addr", d0SysAddr, 32'h0);
        checkOutput("rst sys_ren", {31'b0, d0SysRen}, 32'h0);
        checkOutput("rst m0_ack", {31'b0, d0M0Ack}, 32'h0);
        checkOutput("rst m1_err", {31'b0, d0M1Err}, 32'h0);
        rst = 1'b0;
        tick();

        // Basic read, 1-cycle slave
        applyStimulus(0, 1, 0, 0, 32'h0, 32'h0, 32'h0);
        sample(); checkOutput("rd n+1 sys_ren", {31'b0, d0SysRen}, 32'h0);
        tick(); sample();
        checkOutput("rd n+2 sys_ren", {31'b0, d0SysRen}, 32'h1);
        checkOutput("rd n+2 sys_addr", d0SysAddr, 32'h0);
        tick(); sample(); checkOutput("rd n+3 m0_ack", {31'b0, d0M0Ack}, 32'h0);
        tick(); sample();
        checkOutput("rd n+4 m0_ack", {31'b0, d0M0Ack}, 32'h1);
        checkOutput("rd n+4 m0_rdata", d0M0Rdata, 32'h1);
        checkOutput("rd n+4 m0_err", {31'b0, d0M0Err}, 32'h0);
        checkOutput("rd n+4 d1 m0_ack", {31'b0, d1M0Ack}, 32'h1);
        tick(); sample();
        checkOutput("rd n+5 m0_ack", {31'b0, d0M0Ack}, 32'h0);
        checkOutput("rd n+5 m0_rdata", d0M0Rdata, 32'h0);

        // Slave error is passed through with its read data
        tick();
        applyStimulus(0, 0, 0, 1, 32'h0, 32'hBAD0, 32'h0);
        ticks(3); sample();
        checkOutput("serr m1_ack", {31'b0, d0M1Ack}, 32'h1);
        checkOutput("serr m1_err", {31'b0, d0M1Err}, 32'h1);
        checkOutput("serr m1_rdata", d0M1Rdata, 32'h0000BAD1);
        checkOutput("serr m0_ack", {31'b0, d0M0Ack}, 32'h0);

        // Tie from reset: m0 write first, m1 read three cycles later
        resetDut();
        applyStimulus(1, 0, 0, 1, 32'h10, 32'h20, 32'hAABBCCDD);
        tick(); sample();
        checkOutput("tie1 sys_wen", {31'b0, d0SysWen}, 32'h1);
        checkOutput("tie1 sys_ren", {31'b0, d0SysRen}, 32'h0);
        checkOutput("tie1 sys_addr", d0SysAddr, 32'h10);
        checkOutput("tie1 sys_wdata", d0SysWdata, 32'hAABBCCDD);
        checkOutput("tie1 sys_sel", {28'b0, d0SysSel}, 32'hF);
        checkOutput("tie1 d1 sys_addr", d1SysAddr, 32'h10);
        ticks(2); sample();
        checkOutput("tie1 m0_ack", {31'b0, d0M0Ack}, 32'h1);
        checkOutput("tie1 m1_ack early", {31'b0, d0M1Ack}, 32'h0);
        tick(); sample();
        checkOutput("tie1 m1 sys_ren", {31'b0, d0SysRen}, 32'h1);
        checkOutput("tie1 m1 sys_addr", d0SysAddr, 32'h20);
        checkOutput("tie1 m1 sys_sel", {28'b0, d0SysSel}, 32'h5);
        ticks(2); sample();
        checkOutput("tie1 m1_ack", {31'b0, d0M1Ack}, 32'h1);
        checkOutput("tie1 m1_rdata", d0M1Rdata, 32'h21);
        tick();

        // Second tie with last=m1: m0 first again
        applyStimulus(0, 1, 0, 1, 32'h14, 32'h24, 32'h0);
        tick(); sample();
        checkOutput("tie2 first addr", d0SysAddr, 32'h14);
        ticks(3); sample();
        checkOutput("tie2 second addr", d0SysAddr, 32'h24);
        ticks(3);

        // m0 alone leaves last=m0; next tie goes to m1 under round-robin only
        applyStimulus(0, 1, 0, 0, 32'h30, 32'h0, 32'h0);
        ticks(3); sample();
        checkOutput("solo m0_rdata", d0M0Rdata, 32'h31);
        tick();
        applyStimulus(0, 1, 0, 1, 32'h40, 32'h50, 32'h0);
        tick(); sample();
        checkOutput("tie3 rr first addr", d0SysAddr, 32'h50);
        checkOutput("tie3 fixed first addr", d1SysAddr, 32'h40);
        ticks(3); sample();
        checkOutput("tie3 rr second addr", d0SysAddr, 32'h40);
        checkOutput("tie3 fixed second addr", d1SysAddr, 32'h50);
        ticks(2); sample();
        checkOutput("tie3 rr m0_rdata", d0M0Rdata, 32'h41);
        checkOutput("tie3 fixed m1_rdata", d1M1Rdata, 32'h51);

        // Unresponsive slave: forced error 8 cycles after ISSUE
        resetDut();
        slaveEn = 1'b0;
        applyStimulus(0, 1, 0, 0, 32'h60, 32'h0, 32'h0);
        tick(); sample();
        checkOutput("tmo issue sys_ren", {31'b0, d0SysRen}, 32'h1);
        ticks(7); sample();
        checkOutput("tmo n+9 m0_ack", {31'b0, d0M0Ack}, 32'h0);
        tick(); sample();
        checkOutput("tmo m0_ack", {31'b0, d0M0Ack}, 32'h1);
        checkOutput("tmo m0_err", {31'b0, d0M0Err}, 32'h1);
        checkOutput("tmo m0_rdata", d0M0Rdata, 32'h0);
        checkOutput("tmo d1 m0_err", {31'b0, d1M0Err}, 32'h1);
        tick(); sample();
        checkOutput("tmo end m0_ack", {31'b0, d0M0Ack}, 32'h0);
        checkOutput("tmo end m0_err", {31'b0, d0M0Err}, 32'h0);

        // Overrun on m1: immediate error, only one read reaches the slave
        resetDut();
        slaveEn = 1'b1;
        base = ren0Count;
        applyStimulus(0, 0, 0, 1, 32'h0, 32'h70, 32'h0);
        applyStimulus(0, 0, 0, 1, 32'h0, 32'h74, 32'h0);
        sample();
        checkOutput("ovr m1_ack", {31'b0, d0M1Ack}, 32'h1);
        checkOutput("ovr m1_err", {31'b0, d0M1Err}, 32'h1);
        checkOutput("ovr m1_rdata", d0M1Rdata, 32'h0);
        checkOutput("ovr sys_addr", d0SysAddr, 32'h70);
        tick(); sample();
        checkOutput("ovr n+3 m1_ack", {31'b0, d0M1Ack}, 32'h0);
        tick(); sample();
        checkOutput("ovr done m1_ack", {31'b0, d0M1Ack}, 32'h1);
        checkOutput("ovr done m1_err", {31'b0, d0M1Err}, 32'h0);
        checkOutput("ovr done m1_rdata", d0M1Rdata, 32'h71);
        ticks(3);
        checkOutput("ovr ren count", 32'(ren0Count - base), 32'h1);

        // Reset during WAIT abandons the transaction
        slaveEn = 1'b0;
        applyStimulus(0, 1, 0, 0, 32'h80, 32'h0, 32'h0);
        ticks(2); sample();
        checkOutput("rstw pre sys_addr", d0SysAddr, 32'h80);
        #1 rst = 1'b1;
        #1;
        checkOutput("rstw sys_addr", d0SysAddr, 32'h0);
        checkOutput("rstw d1 sys_addr", d1SysAddr, 32'h0);
        tick(); tick();
        rst = 1'b0;
        slaveEn = 1'b1;
        base = ack0Count;
        ticks(12);
        checkOutput("rstw no ack", 32'(ack0Count - base), 32'h0);
        checkOutput("rstw sys_ren", {31'b0, d0SysRen}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
